pipe_interlock: RTL and testbench

Hazard interlock and issue controller for the five-stage mips32 pipeline (IF, ID, EX, MEM, WB). It sits beside the ID stage and tracks in-flight register writes in a short issue-history shift register. It stalls IF/ID and injects EX bubbles while a source register is pending, which removes the hand-placed NOP padding from programs. It also kills younger instructions on a taken branch and latches the halt condition.

---
 rtl/mips_pkg.sv | 16 +
 rtl/reg_busy_cam.sv | 26 ++
 rtl/pipe_interlock.sv | 94 +++++++++
 tb/tb_pipe_interlock.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared mips32 pipeline definitions: register width, depth, encodings and
// the interlock controller state.
package mips_pkg;

   localparam int          REG_W       = 5;
   localparam int          PIPE_DEPTH  = 5;
   localparam int          LAT_DEFAULT = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam logic [5:0]  OP_HLT      = 6'b111111;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

endpackage

// File: rtl/reg_busy_cam.sv
// Compares one source register against every live entry of the issue
// history; R0 is hardwired and never reported busy.
module reg_busy_cam
   import mips_pkg::*;
#(
   parameter int LAT = LAT_DEFAULT
) (
   input  logic [LAT-1:0]            hist_v,
   input  logic [LAT-1:0][REG_W-1:0] hist_rd,
   input  logic [REG_W-1:0]          addr,
   output logic                      busy
);

   // NOTE: busy gets a default before the loop so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         if (hist_v[i] && (hist_rd[i] == addr))
            busy = 1'b1;
      end
      if (addr == '0)
         busy = 1'b0;
   end

endmodule

// File: rtl/pipe_interlock.sv
// ID-stage hazard interlock: tracks in-flight register writes, stalls IF/ID
// and bubbles EX while a source is pending, kills on flush, latches HLT.
module pipe_interlock
   import mips_pkg::*;
#(
   parameter int LAT  = LAT_DEFAULT,
   parameter int KILL = 2,
   parameter int CW   = 16
) (
   input  logic             clk_x,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_wr_addr,
   input  logic             id_is_halt,
   input  logic             flush,
   output logic             pc_hold,
   output logic             ex_bubble,
   output logic             halted,
   output logic [CW-1:0]    stall_cnt
);

   state_t                    state, state_nxt;
   logic [LAT-1:0]            hist_v;
   logic [LAT-1:0][REG_W-1:0] hist_rd;
   logic                      rs_busy, rt_busy;
   logic                      hz, issue, kill_en, stall;

   reg_busy_cam #(.LAT(LAT)) u_cam_rs (
      .hist_v  (hist_v),
      .hist_rd (hist_rd),
      .addr    (id_rs),
      .busy    (rs_busy)
   );

   reg_busy_cam #(.LAT(LAT)) u_cam_rt (
      .hist_v  (hist_v),
      .hist_rd (hist_rd),
      .addr    (id_rt),
      .busy    (rt_busy)
   );

   assign hz      = id_valid && ((id_uses_rs && rs_busy) || (id_uses_rt && rt_busy));
   // ID contents are ignored while reset is applied.
   assign issue   = id_valid && !hz && !flush && !rst && (state == RUN);
   assign kill_en = flush && (state == RUN);
   assign stall   = (state == RUN) && hz && !flush;
   assign halted  = (state == HALT);

   always_comb begin
      state_nxt = state;
      pc_hold   = 1'b1;
      ex_bubble = 1'b1;
      case (state)
         RUN: begin
            pc_hold   = hz && !flush;
            ex_bubble = !issue;
            if (issue && id_is_halt)
               state_nxt = HALT;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, making the history shift order-independent.
   always_ff @(posedge clk_x) begin
      if (rst) begin
         state     <= RUN;
         hist_v    <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         hist_v[0] <= issue && id_wr_en && (id_wr_addr != '0);
         for (int i = 1; i < LAT; i++)
            hist_v[i] <= hist_v[i-1] && !(kill_en && ((i - 1) < KILL));
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CW'(1);
      end
   end

   // NOTE: destination fields are left unreset; their valid bits gate them,
   // so resetting the payload would only cost reset fan-out.
   always_ff @(posedge clk_x) begin
      hist_rd[0] <= id_wr_addr;
      for (int i = 1; i < LAT; i++)
         hist_rd[i] <= hist_rd[i-1];
   end

endmodule

// File: tb/tb_pipe_interlock.sv
// Directed-vector bench for pipe_interlock: load-use, independent issue, R0,
// flush kill, halt, reset mid-stall and counter saturation.
module tb_pipe_interlock;
   import mips_pkg::*;

   logic        clk_x = 1'b0;
   logic        rst;
   logic        id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_halt, flush;
   logic [4:0]  id_rs, id_rt, id_wr_addr;
   logic        pc_hold, ex_bubble, halted;
   logic [15:0] stall_cnt;

   // Second instance with a long latency, used only to saturate the counter.
   logic        s_rst, s_valid, s_uses_rs, s_uses_rt, s_wr_en, s_is_halt, s_flush;
   logic [4:0]  s_rs, s_rt, s_wr_addr;
   logic        s_pc_hold, s_ex_bubble, s_halted;
   logic [15:0] s_stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk_x = ~clk_x;

   pipe_interlock #(.LAT(4), .KILL(2), .CW(16)) dut (
      .clk_x(clk_x), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
      .id_wr_addr(id_wr_addr), .id_is_halt(id_is_halt), .flush(flush),
      .pc_hold(pc_hold), .ex_bubble(ex_bubble), .halted(halted), .stall_cnt(stall_cnt)
   );

   pipe_interlock #(.LAT(64), .KILL(2), .CW(16)) dut_sat (
      .clk_x(clk_x), .rst(s_rst), .id_valid(s_valid), .id_rs(s_rs), .id_rt(s_rt),
      .id_uses_rs(s_uses_rs), .id_uses_rt(s_uses_rt), .id_wr_en(s_wr_en),
      .id_wr_addr(s_wr_addr), .id_is_halt(s_is_halt), .flush(s_flush),
      .pc_hold(s_pc_hold), .ex_bubble(s_ex_bubble), .halted(s_halted), .stall_cnt(s_stall_cnt)
   );

   task automatic step();
      @(posedge clk_x);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [4:0] wa, input logic hl, input logic fl);
      id_valid = v;   id_rs = rs;       id_rt = rt;
      id_uses_rs = urs; id_uses_rt = urt; id_wr_en = we;
      id_wr_addr = wa; id_is_halt = hl;  flush = fl;
   endtask

   // A decoded NOP presents id_valid=0 with all other fields cleared.
   task automatic idle();
      logic [31:0] w;
      w = NOP_INSTR;
      drive(1'b0, w[25:21], w[20:16], 1'b0, 1'b0, 1'b0, w[15:11], 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      step();
      settle();
      checks++;
      if (ex_bubble !== 1'b1) begin
         failures++;
         $display("FAIL reset_active_bubble: got %b want 1", ex_bubble);
      end
      step();
      rst = 1'b0;
      idle();
      settle();
      checks++;
      if ({pc_hold, ex_bubble, halted} !== 3'b010) begin
         failures++;
         $display("FAIL reset_outputs: got hold/bub/halt=%b want 010", {pc_hold, ex_bubble, halted});
      end
      checks++;
      if (stall_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);   // lw R1
      settle();
      checks++;
      if ({pc_hold, ex_bubble} !== 2'b00) begin
         failures++;
         $display("FAIL load_issue c0: got hold/bub=%b want 00", {pc_hold, ex_bubble});
      end
      step();
      drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);   // add R3=R1+R2
      for (int c = 1; c <= 4; c++) begin
         settle();
         checks++;
         if ({pc_hold, ex_bubble} !== 2'b11) begin
            failures++;
            $display("FAIL load_use_stall c%0d: got hold/bub=%b want 11", c, {pc_hold, ex_bubble});
         end
         step();
      end
      settle();
      checks++;
      if ({pc_hold, ex_bubble} !== 2'b00) begin
         failures++;
         $display("FAIL load_use_issue c5: got hold/bub=%b want 00", {pc_hold, ex_bubble});
      end
      checks++;
      if (stall_cnt !== 16'd4) begin
         failures++;
         $display("FAIL load_use_stall_cnt: got %0d want 4", stall_cnt);
      end
      step();
      idle();
   endtask

   task automatic test_back_to_back();
      int issues;
      int holds;
      do_reset();
      issues = 0;
      holds  = 0;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 5'(9 + k), 5'(17 + k), 1'b1, 1'b1, 1'b1, 5'(1 + k), 1'b0, 1'b0);
         settle();
         if (!ex_bubble) issues++;
         if (pc_hold)    holds++;
         step();
      end
      idle();
      settle();
      checks++;
      if (issues !== 8) begin
         failures++;
         $display("FAIL b2b_issues: got %0d want 8", issues);
      end
      checks++;
      if (holds !== 0) begin
         failures++;
         $display("FAIL b2b_holds: got %0d want 0", holds);
      end
      checks++;
      if (stall_cnt !== 16'd0) begin
         failures++;
         $display("FAIL b2b_stall_cnt: got %0d want 0", stall_cnt);
      end
   endtask

   task automatic test_r0();
      do_reset();
      drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);    // writes R0
      step();
      drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);    // reads R0
      settle();
      checks++;
      if ({pc_hold, ex_bubble} !== 2'b00) begin
         failures++;
         $display("FAIL r0_no_stall: got hold/bub=%b want 00", {pc_hold, ex_bubble});
      end
      step();
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);    // producer R5
      step();
      // Wrong-path instruction depends on R5 and writes R6; flush kills it.
      drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1);
      settle();
      checks++;
      if ({pc_hold, ex_bubble} !== 2'b01) begin
         failures++;
         $display("FAIL flush_cycle: got hold/bub=%b want 01", {pc_hold, ex_bubble});
      end
      step();
      drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      settle();
      checks++;
      if ({pc_hold, ex_bubble} !== 2'b00) begin
         failures++;
         $display("FAIL flush_consumer: got hold/bub=%b want 00", {pc_hold, ex_bubble});
      end
      checks++;
      if (stall_cnt !== 16'd0) begin
         failures++;
         $display("FAIL flush_stall_cnt: got %0d want 0", stall_cnt);
      end
      step();
      idle();
   endtask

   task automatic test_halt();
      logic [31:0] w;
      int          bad;
      w = {OP_HLT, 26'd0};
      w[25:21] = 5'd1;
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);    // producer R1
      step();
      drive(1'b1, w[25:21], 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, (w[31:26] == OP_HLT), 1'b0);
      for (int c = 1; c <= 4; c++) step();
      settle();
      checks++;
      if ({halted, ex_bubble} !== 2'b00) begin
         failures++;
         $display("FAIL halt_issue: got halted/bub=%b want 00", {halted, ex_bubble});
      end
      step();
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'(k % 2));
         settle();
         if ({halted, pc_hold, ex_bubble} !== 3'b111) bad++;
         step();
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL halt_hold: got %0d bad cycles want 0", bad);
      end
      checks++;
      if (stall_cnt !== 16'd4) begin
         failures++;
         $display("FAIL halt_stall_cnt: got %0d want 4", stall_cnt);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      settle();
      checks++;
      if ({halted, stall_cnt} !== {1'b0, 16'd0}) begin
         failures++;
         $display("FAIL halt_release: got halted=%b cnt=%0d want 0/0", halted, stall_cnt);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
      settle();
      checks++;
      if (pc_hold !== 1'b1) begin
         failures++;
         $display("FAIL midstall_first: got hold=%b want 1", pc_hold);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      settle();
      checks++;
      if ({pc_hold, ex_bubble, stall_cnt} !== {2'b00, 16'd0}) begin
         failures++;
         $display("FAIL midstall_release: got hold/bub=%b cnt=%0d want 00/0", {pc_hold, ex_bubble}, stall_cnt);
      end
      step();
      idle();
   endtask

   // Repeated R1=R1+R1 with LAT=64: one issue then 64 stall cycles, period 65.
   task automatic test_saturation();
      int hz_seen;
      int bad;
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      s_valid = 1'b1;
      hz_seen = 0;
      bad = 0;
      for (int k = 0; k < 80000 && hz_seen < 70000; k++) begin
         settle();
         if (s_pc_hold !== ((k % 65) != 0)) bad++;
         if (hz_seen == 1000 && (k % 65) != 0 && ((k - 1) % 65) != 0) begin
            checks++;
            if (s_stall_cnt !== 16'd1000) begin
               failures++;
               $display("FAIL sat_midpoint: got %0d want 1000", s_stall_cnt);
            end
         end
         if ((k % 65) != 0) hz_seen++;
         step();
      end
      s_valid = 1'b0;
      settle();
      checks++;
      if (hz_seen !== 70000) begin
         failures++;
         $display("FAIL sat_budget: got %0d hazard cycles want 70000", hz_seen);
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL sat_hold_pattern: got %0d bad cycles want 0", bad);
      end
      checks++;
      if (s_stall_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_value: got %h want ffff", s_stall_cnt);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      s_rst = 1'b1;  s_valid = 1'b0;
      s_rs = 5'd1;   s_rt = 5'd0;    s_uses_rs = 1'b1; s_uses_rt = 1'b0;
      s_wr_en = 1'b1; s_wr_addr = 5'd1; s_is_halt = 1'b0; s_flush = 1'b0;
      test_reset();
      test_load_use();
      test_back_to_back();
      test_r0();
      test_flush();
      test_halt();
      test_reset_mid_stall();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
